// File: rtl/exec_pkg.sv
// exec_pkg: shared constants and types for the Y86-64 execute stage.
// Holds icode values, ALU op codes, CC bit indices, condition codes and the +/-8 stack constants.
package exec_pkg;

    // Y86-64 instruction codes
    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    // ALU operation select
    typedef enum logic [1:0] {
        ALU_ADD = 2'b00,
        ALU_SUB = 2'b01,
        ALU_AND = 2'b10,
        ALU_XOR = 2'b11
    } alu_op_e;

    // Condition-code bit positions (same order as alu_cf)
    localparam int CC_ZF = 2;
    localparam int CC_SF = 1;
    localparam int CC_OF = 0;

    localparam logic [2:0] CC_RESET = 3'b100;

    // Condition function codes for cmovXX / jXX
    localparam logic [3:0] C_YES = 4'h0;
    localparam logic [3:0] C_LE  = 4'h1;
    localparam logic [3:0] C_L   = 4'h2;
    localparam logic [3:0] C_E   = 4'h3;
    localparam logic [3:0] C_NE  = 4'h4;
    localparam logic [3:0] C_GE  = 4'h5;
    localparam logic [3:0] C_G   = 4'h6;

    // Largest legal function code for OPq and for conditional ops
    localparam logic [3:0] OPQ_FN_MAX  = 4'h3;
    localparam logic [3:0] COND_FN_MAX = 4'h6;

    // Stack pointer adjustments, sign-extended to 64 bits
    localparam logic [63:0] NEG8 = 64'hFFFF_FFFF_FFFF_FFF8;
    localparam logic [63:0] POS8 = 64'h0000_0000_0000_0008;

    // Output slot state
    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_e;

endpackage

// File: rtl/execute_ctrl_cond_eval.sv
// cond_eval: combinational branch/move condition from condition codes and ifun.
// Ports: cc[2:0] (ZF,SF,OF) and ifun[3:0] in; cnd out (0 for undefined ifun).
module cond_eval
    import exec_pkg::*;
(
    input  logic [2:0] cc,
    input  logic [3:0] ifun,
    output logic       cnd
);

    logic zf;
    logic sf;
    logic of;
    logic lt;

    assign zf = cc[CC_ZF];
    assign sf = cc[CC_SF];
    assign of = cc[CC_OF];

    // Signed less-than as seen by the last compare
    assign lt = sf ^ of;

    always_comb begin
        cnd = 1'b0;
        case (ifun)
            C_YES:   cnd = 1'b1;
            C_LE:    cnd = lt | zf;
            C_L:     cnd = lt;
            C_E:     cnd = zf;
            C_NE:    cnd = !zf;
            C_GE:    cnd = !lt;
            C_G:     cnd = !lt & !zf;
            default: cnd = 1'b0;
        endcase
    end

endmodule

// File: rtl/execute_ctrl.sv
// execute_ctrl: Y86-64 execute stage control; drives an external ALU and registers its result.
// Ports: clk/rst, in_valid/in_ready + icode/ifun/valA/valB/valC in, alu_* drive/return,
//        out_valid/out_ready + valE/cnd out, cc register; ins_err only with EXEC_INS_ERR_EN.
module execute_ctrl
    import exec_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  icode,
    input  logic [3:0]  ifun,
    input  logic [63:0] valA,
    input  logic [63:0] valB,
    input  logic [63:0] valC,
    output logic [1:0]  alu_ctrl,
    output logic [63:0] alu_a,
    output logic [63:0] alu_b,
    input  logic [63:0] alu_out,
    input  logic [2:0]  alu_cf,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] valE,
    output logic        cnd,
`ifdef EXEC_INS_ERR_EN
    output logic        ins_err,
`endif
    output logic [2:0]  cc
);

    slot_state_e state_q, state_d;
    logic [63:0] val_e_q, val_e_d;
    logic        cnd_q, cnd_d;
    logic [2:0]  cc_q, cc_d;
    logic        ins_err_q, ins_err_d;

    logic [63:0] op_a;
    logic [63:0] op_b;
    logic        accept;
    logic        cnd_w;
    logic        err_w;

    // Operand A: register, immediate or stack step
    always_comb begin
        op_a = '0;
        case (icode)
            I_RRMOVQ, I_OPQ:              op_a = valA;
            I_IRMOVQ, I_RMMOVQ, I_MRMOVQ: op_a = valC;
            I_CALL, I_PUSHQ:              op_a = NEG8;
            I_RET, I_POPQ:                op_a = POS8;
            default:                      op_a = '0;
        endcase
    end

    // Operand B: base register where one exists
    always_comb begin
        op_b = '0;
        case (icode)
            I_RMMOVQ, I_MRMOVQ, I_OPQ,
            I_CALL, I_RET,
            I_PUSHQ, I_POPQ: op_b = valB;
            default:         op_b = '0;
        endcase
    end

    // Result is B op A so that subq gives valB - valA
    always_comb begin
        alu_ctrl = ALU_ADD;
        if (icode == I_OPQ) begin
            alu_ctrl = ifun[1:0];
        end
    end

    assign alu_a = op_b;
    assign alu_b = op_a;

    // Illegal-instruction detection
`ifdef EXEC_INS_ERR_EN
    always_comb begin
        err_w = 1'b0;
        unique case (1'b1)
            (icode > I_POPQ):
                err_w = 1'b1;
            (icode == I_OPQ):
                err_w = (ifun > OPQ_FN_MAX);
            (icode == I_RRMOVQ),
            (icode == I_JXX):
                err_w = (ifun > COND_FN_MAX);
            default:
                err_w = 1'b0;
        endcase
    end
`else
    assign err_w = 1'b0;
`endif

    // Condition uses the register value before any update on this edge
    cond_eval u_cond_eval (
        .cc   (cc_q),
        .ifun (ifun),
        .cnd  (cnd_w)
    );

    assign out_valid = (state_q == SLOT_FULL);
    assign in_ready  = !out_valid || out_ready;
    assign accept    = in_valid && in_ready;

    always_comb begin
        state_d   = state_q;
        val_e_d   = val_e_q;
        cnd_d     = cnd_q;
        cc_d      = cc_q;
        ins_err_d = ins_err_q;

        case (state_q)
            SLOT_EMPTY: begin
                if (accept) begin
                    state_d = SLOT_FULL;
                end
            end
            SLOT_FULL: begin
                if (out_ready && !accept) begin
                    state_d = SLOT_EMPTY;
                end
            end
            default: state_d = SLOT_EMPTY;
        endcase

        if (accept) begin
            val_e_d   = alu_out;
            cnd_d     = cnd_w;
            ins_err_d = err_w;
            if ((icode == I_OPQ) && !err_w) begin
                cc_d = alu_cf;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= SLOT_EMPTY;
            val_e_q   <= '0;
            cnd_q     <= 1'b0;
            cc_q      <= CC_RESET;
            ins_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            val_e_q   <= val_e_d;
            cnd_q     <= cnd_d;
            cc_q      <= cc_d;
            ins_err_q <= ins_err_d;
        end
    end

    assign valE = val_e_q;
    assign cnd  = cnd_q;
    assign cc   = cc_q;

`ifdef EXEC_INS_ERR_EN
    assign ins_err = ins_err_q;
`else
    // Error flag is tied off without the checker build
    logic unused_err;
    assign unused_err = ins_err_q ^ ins_err_d;
`endif

endmodule
